// File: rtl/lif_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module      : lif_spike_decoder
// Description : Rate decoder for the output end of the systolic LIF neuron
//               array. Counts spikes per channel over a window of WIN_LEN
//               accepted samples, then streams one count beat per channel
//               over a valid/ready port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_CH     number of spike channels (>= 2)
//   CNT_W    per-channel counter width, counts saturate at 2^CNT_W-1
//   WIN_LEN  window length in accepted samples (>= 1)
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   start_i        begin a window (honoured only while idle)
//   spike_valid_i  spike_in_i carries a sample this cycle
//   spike_in_i     spike vector, bit i = neuron i fired
//   out_valid_o    count beat presented
//   out_ready_i    downstream accepts the beat
//   out_ch_o       channel index of the current beat
//   out_count_o    spike count of channel out_ch_o
//   out_sat_o      channel out_ch_o saturated during the window
//   out_last_o     current beat is channel N_CH-1
//   busy_o         decoder is not idle
//   drop_o         one-cycle pulse: a sample arrived while dumping and was lost
// Build options
//   DECODER_AUTORESTART_EN  when defined, the decoder re-enters collection
//                           with cleared counters right after the last beat
//                           instead of returning to idle.
// ============================================================================
module lif_spike_decoder #(
  parameter int N_CH    = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    spike_valid_i,
  input  logic [N_CH-1:0]         spike_in_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(N_CH)-1:0] out_ch_o,
  output logic [CNT_W-1:0]        out_count_o,
  output logic                    out_sat_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    drop_o
);

  localparam int CH_W  = $clog2(N_CH);
  // A window of one sample still needs a one-bit sample counter.
  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  localparam logic [CH_W-1:0]  C_LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [WIN_W-1:0] C_LAST_SMP = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DUMP    = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CH_W-1:0]   ch_idx_q;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   sat_q;
  logic [N_CH-1:0]   sat_d;
  logic              drop_q;

  logic w_sample;
  logic w_beat;
  logic w_last_beat;
  logic w_clear;
  logic w_dump;

  assign w_dump      = (state_q == S_DUMP);
  assign w_sample    = (state_q == S_COLLECT) && spike_valid_i;
  assign w_beat      = w_dump && out_ready_i;
  assign w_last_beat = w_beat && (ch_idx_q == C_LAST_CH);

`ifdef DECODER_AUTORESTART_EN
  // Counters are cleared both on an explicit start and when the last beat
  // leaves, so the next window begins from zero without a start pulse.
  assign w_clear = ((state_q == S_IDLE) && start_i) || w_last_beat;
`else
  assign w_clear = (state_q == S_IDLE) && start_i;
`endif

  // Per-channel counter next state. A channel already at full scale keeps
  // its value and latches its sticky saturation flag instead of wrapping.
  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_clear) begin
        cnt_d[i] = '0;
        sat_d[i] = 1'b0;
      end else if (w_sample && spike_in_i[i]) begin
        if (cnt_q[i] == C_CNT_MAX) begin
          sat_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      ch_idx_q  <= '0;
      sat_q     <= '0;
      drop_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sat_q  <= sat_d;
      drop_q <= w_dump && spike_valid_i;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_COLLECT;
            win_cnt_q <= '0;
          end
        end

        S_COLLECT: begin
          if (spike_valid_i) begin
            // The window-closing sample is counted in this same cycle.
            if (win_cnt_q == C_LAST_SMP) begin
              state_q   <= S_DUMP;
              win_cnt_q <= '0;
              ch_idx_q  <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
            end
          end
        end

        S_DUMP: begin
          if (out_ready_i) begin
            if (ch_idx_q == C_LAST_CH) begin
              ch_idx_q <= '0;
`ifdef DECODER_AUTORESTART_EN
              state_q   <= S_COLLECT;
              win_cnt_q <= '0;
`else
              state_q   <= S_IDLE;
`endif
            end else begin
              ch_idx_q <= ch_idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Beat fields are decoded purely from registered state and forced to zero
  // outside the dump phase, so the port is quiet while collecting.
  assign out_valid_o = w_dump;
  assign out_ch_o    = w_dump ? ch_idx_q : '0;
  assign out_count_o = w_dump ? cnt_q[ch_idx_q] : '0;
  assign out_sat_o   = w_dump && sat_q[ch_idx_q];
  assign out_last_o  = w_dump && (ch_idx_q == C_LAST_CH);
  assign busy_o      = (state_q != S_IDLE);
  assign drop_o      = drop_q;

endmodule
`default_nettype wire
